// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard unit: exception FSM encoding,
// default redirect constants and execute-stage forwarding selects.
package hazard_scoreboard_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StFlush    = 2'd1,
        StRedirect = 2'd2
    } hz_state_e;

    localparam logic [31:0] EXC_VEC   = 32'hBFC00380;
    localparam logic [31:0] ERET_CODE = 32'h0000000E;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side bundle of the hazard unit. The slave modport is the hazard
// unit itself; the master modport is the pipeline that drives it.
interface hazard_scoreboard_if #(
    parameter int unsigned AW   = 5,
    parameter int unsigned CNTW = 16
);
    logic [AW-1:0]   rsD;
    logic [AW-1:0]   rtD;
    logic [AW-1:0]   rsE;
    logic [AW-1:0]   rtE;
    logic            issue_valid;
    logic            issue_long;
    logic [AW-1:0]   issue_wreg;
    logic            lwb_valid;
    logic [AW-1:0]   lwb_reg;
    logic [AW-1:0]   writeregM;
    logic [AW-1:0]   writeregW;
    logic            regwriteM;
    logic            regwriteW;
    logic            memtoregE;
    logic            stallreq_mem;
    logic [31:0]     excepttypeM;
    logic [31:0]     cp0_epcM;
    logic            pc_ready;

    logic            stallF;
    logic            stallD;
    logic            stallE;
    logic            stallM;
    logic            flushF;
    logic            flushD;
    logic            flushE;
    logic            flushM;
    logic            flushW;
    logic [1:0]      forwardaE;
    logic [1:0]      forwardbE;
    logic            redirect_valid;
    logic [31:0]     redirect_pc;
    logic            sb_full;
    logic [CNTW-1:0] stall_cnt;

    modport master (
        output rsD, rtD, rsE, rtE, issue_valid, issue_long, issue_wreg,
               lwb_valid, lwb_reg, writeregM, writeregW, regwriteM, regwriteW,
               memtoregE, stallreq_mem, excepttypeM, cp0_epcM, pc_ready,
        input  stallF, stallD, stallE, stallM, flushF, flushD, flushE, flushM,
               flushW, forwardaE, forwardbE, redirect_valid, redirect_pc,
               sb_full, stall_cnt
    );

    modport slave (
        input  rsD, rtD, rsE, rtE, issue_valid, issue_long, issue_wreg,
               lwb_valid, lwb_reg, writeregM, writeregW, regwriteM, regwriteW,
               memtoregE, stallreq_mem, excepttypeM, cp0_epcM, pc_ready,
        output stallF, stallD, stallE, stallM, flushF, flushD, flushE, flushM,
               flushW, forwardaE, forwardbE, redirect_valid, redirect_pc,
               sb_full, stall_cnt
    );

endinterface

// File: rtl/hz_scoreboard.sv
// Pending-register scoreboard for long-latency producers: one pending bit per
// architectural register plus a count of outstanding producers.
module hz_scoreboard #(
    parameter int unsigned NREG     = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned SB_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          set_en,
    input  logic [AW-1:0] set_reg,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_reg,
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rt,
    output logic          rs_busy,
    output logic          rt_busy,
    output logic          full
);

    localparam int unsigned CW = $clog2(SB_DEPTH + 1);

    logic [NREG-1:0] pend_q, pend_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            set_hit, clr_hit;
    logic            rs_pend, rt_pend;

    // Source lookup; a writeback to the same register this cycle bypasses it.
    always_comb begin
        rs_pend = 1'b0;
        rt_pend = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (rs == AW'(i)) rs_pend = pend_q[i];
            if (rt == AW'(i)) rt_pend = pend_q[i];
        end
        rs_busy = rs_pend & ~(clr_en & (clr_reg == rs));
        rt_busy = rt_pend & ~(clr_en & (clr_reg == rt));
    end

    // Next pending bits and count; register 0 is skipped, set wins over clear.
    always_comb begin
        pend_d  = pend_q;
        set_hit = 1'b0;
        clr_hit = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            if (clr_en && (clr_reg == AW'(i)) && pend_q[i]) begin
                pend_d[i] = 1'b0;
                clr_hit   = 1'b1;
            end
            if (set_en && (set_reg == AW'(i))) begin
                pend_d[i] = 1'b1;
                set_hit   = 1'b1;
            end
        end
        cnt_d = cnt_q;
        if (set_hit && !clr_hit) begin
            cnt_d = cnt_q + 1'b1;
        end else if (clr_hit && !set_hit) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (flush) begin
            pend_d = '0;
            cnt_d  = '0;
        end
    end

    // Scoreboard state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign full = (cnt_q == CW'(SB_DEPTH));

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: execute-stage forwarding, load-use and long-latency
// stalls, and the exception flush/redirect sequencer.
module hazard_scoreboard #(
    parameter int unsigned NREG      = 32,
    parameter int unsigned AW        = 5,
    parameter int unsigned SB_DEPTH  = 4,
    parameter int unsigned CNTW      = 16,
    parameter logic [31:0] EXC_VEC   = hazard_scoreboard_pkg::EXC_VEC,
    parameter logic [31:0] ERET_CODE = hazard_scoreboard_pkg::ERET_CODE
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave bus
);

    import hazard_scoreboard_pkg::*;

    hz_state_e       state_q, state_d;
    logic [31:0]     redirect_pc_q, redirect_pc_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

    logic lwb_eff, set_en, flush_sb;
    logic rs_busy, rt_busy, sb_full;
    logic lwstall, sb_stall, redir_wait, stall_dec;
    logic fl_f, fl_d, fl_e, fl_m, fl_w;

    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src,
                                           input logic [AW-1:0] wreg_m,
                                           input logic          wen_m,
                                           input logic [AW-1:0] wreg_w,
                                           input logic          wen_w);
        if ((src != '0) && (src == wreg_m) && wen_m) return FWD_M;
        if ((src != '0) && (src == wreg_w) && wen_w) return FWD_W;
        return FWD_NONE;
    endfunction

    // Long writebacks during the flush/redirect window belong to cancelled work.
    always_comb begin
        lwb_eff    = bus.lwb_valid & (state_q == StIdle);
        flush_sb   = (state_q == StFlush);
        lwstall    = bus.memtoregE & ((bus.rsD == bus.rtE) | (bus.rtD == bus.rtE));
        sb_stall   = rs_busy | rt_busy | (bus.issue_long & sb_full);
        redir_wait = (state_q == StRedirect) & ~bus.pc_ready;
        stall_dec  = sb_stall | lwstall | bus.stallreq_mem | redir_wait;
        set_en     = bus.issue_valid & bus.issue_long & ~stall_dec & (bus.issue_wreg != '0);
    end

    hz_scoreboard #(
        .NREG     (NREG),
        .AW       (AW),
        .SB_DEPTH (SB_DEPTH)
    ) u_sb (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush_sb),
        .set_en  (set_en),
        .set_reg (bus.issue_wreg),
        .clr_en  (lwb_eff),
        .clr_reg (bus.lwb_reg),
        .rs      (bus.rsD),
        .rt      (bus.rtD),
        .rs_busy (rs_busy),
        .rt_busy (rt_busy),
        .full    (sb_full)
    );

    // Exception sequencer next state; the target is latched on entry only.
    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        unique case (state_q)
            StIdle: begin
                if (bus.excepttypeM != '0) begin
                    state_d       = StFlush;
                    redirect_pc_d = (bus.excepttypeM == ERET_CODE) ? bus.cp0_epcM : EXC_VEC;
                end
            end
            StFlush:    state_d = StRedirect;
            StRedirect: if (bus.pc_ready) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Saturating count of decode-stall cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_dec && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // FSM, redirect target and stall counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            redirect_pc_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    // Flush outputs; reset forces them low even though some are combinational.
    always_comb begin
        fl_f = 1'b0;
        fl_d = 1'b0;
        fl_e = lwstall | sb_stall;
        fl_m = 1'b0;
        fl_w = bus.stallreq_mem;
        if (state_q == StFlush) begin
            fl_f = 1'b1;
            fl_d = 1'b1;
            fl_e = 1'b1;
            fl_m = 1'b1;
            fl_w = 1'b1;
        end
        if (rst) begin
            fl_f = 1'b0;
            fl_d = 1'b0;
            fl_e = 1'b0;
            fl_m = 1'b0;
            fl_w = 1'b0;
        end
    end

    // Drive the pipeline-facing outputs.
    always_comb begin
        bus.stallF         = stall_dec;
        bus.stallD         = stall_dec;
        bus.stallE         = bus.stallreq_mem;
        bus.stallM         = bus.stallreq_mem;
        bus.flushF         = fl_f;
        bus.flushD         = fl_d;
        bus.flushE         = fl_e;
        bus.flushM         = fl_m;
        bus.flushW         = fl_w;
        bus.forwardaE      = fwd_sel(bus.rsE, bus.writeregM, bus.regwriteM,
                                     bus.writeregW, bus.regwriteW);
        bus.forwardbE      = fwd_sel(bus.rtE, bus.writeregM, bus.regwriteM,
                                     bus.writeregW, bus.regwriteW);
        bus.redirect_valid = (state_q == StRedirect);
        bus.redirect_pc    = redirect_pc_q;
        bus.sb_full        = sb_full;
        bus.stall_cnt      = stall_cnt_q;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the hazard rules.
module tb_hazard_scoreboard;

    localparam int          AW        = 5;
    localparam int          SB_DEPTH  = 4;
    localparam int          CNTW      = 4;
    localparam int          SCNT_MAX  = (1 << CNTW) - 1;
    localparam logic [31:0] EXC_ADDR  = 32'hBFC00380;
    localparam logic [31:0] ERET      = 32'h0000000E;
    localparam int          M_IDLE    = 0;
    localparam int          M_FLUSH   = 1;
    localparam int          M_RED     = 2;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    hazard_scoreboard_if #(.AW(AW), .CNTW(CNTW)) hz_bus ();

    hazard_scoreboard #(
        .NREG     (32),
        .AW       (AW),
        .SB_DEPTH (SB_DEPTH),
        .CNTW     (CNTW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (hz_bus)
    );

    always #5 clk = ~clk;

    // Model state
    int          m_mode;
    bit          m_pend[32];
    int          m_cnt;
    logic [31:0] m_rpc;
    int          m_scnt;

    // Model expectations for the current inputs
    bit e_stall, e_sb, e_lw;
    bit e_ff, e_fd, e_fe, e_fm, e_fw;
    int e_fwa, e_fwb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int fwd(input int src, input int wm, input bit rm,
                               input int ww, input bit rw);
        if (src != 0 && src == wm && rm) return 2;
        if (src != 0 && src == ww && rw) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_cnt  = 0;
        m_rpc  = 32'h0;
        m_scnt = 0;
    endtask

    task automatic model_eval();
        bit lwb_eff, busy_rs, busy_rt;
        int rs, rt;
        rs = int'(hz_bus.rsD);
        rt = int'(hz_bus.rtD);
        lwb_eff = hz_bus.lwb_valid && (m_mode == M_IDLE);
        busy_rs = m_pend[rs] && !(lwb_eff && int'(hz_bus.lwb_reg) == rs);
        busy_rt = m_pend[rt] && !(lwb_eff && int'(hz_bus.lwb_reg) == rt);
        e_sb = busy_rs || busy_rt || (hz_bus.issue_long && m_cnt == SB_DEPTH);
        e_lw = hz_bus.memtoregE && (hz_bus.rsD == hz_bus.rtE || hz_bus.rtD == hz_bus.rtE);
        e_stall = e_sb || e_lw || hz_bus.stallreq_mem || (m_mode == M_RED && !hz_bus.pc_ready);
        if (m_mode == M_FLUSH) begin
            {e_ff, e_fd, e_fe, e_fm, e_fw} = 5'b11111;
        end else begin
            e_ff = 0; e_fd = 0; e_fm = 0;
            e_fe = e_lw || e_sb;
            e_fw = hz_bus.stallreq_mem;
        end
        e_fwa = fwd(int'(hz_bus.rsE), int'(hz_bus.writeregM), hz_bus.regwriteM,
                    int'(hz_bus.writeregW), hz_bus.regwriteW);
        e_fwb = fwd(int'(hz_bus.rtE), int'(hz_bus.writeregM), hz_bus.regwriteM,
                    int'(hz_bus.writeregW), hz_bus.regwriteW);
    endtask

    task automatic model_update();
        bit do_set, do_clr;
        model_eval();
        if (m_mode == M_FLUSH) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_cnt  = 0;
            m_mode = M_RED;
        end else begin
            do_set = hz_bus.issue_valid && hz_bus.issue_long && !e_stall && hz_bus.issue_wreg != 0;
            do_clr = hz_bus.lwb_valid && m_mode == M_IDLE && m_pend[int'(hz_bus.lwb_reg)];
            if (do_clr) m_pend[int'(hz_bus.lwb_reg)] = 1'b0;
            if (do_set) m_pend[int'(hz_bus.issue_wreg)] = 1'b1;
            m_cnt = m_cnt + int'(do_set) - int'(do_clr);
            if (m_mode == M_IDLE && hz_bus.excepttypeM != 0) begin
                m_mode = M_FLUSH;
                m_rpc  = (hz_bus.excepttypeM == ERET) ? hz_bus.cp0_epcM : EXC_ADDR;
            end else if (m_mode == M_RED && hz_bus.pc_ready) begin
                m_mode = M_IDLE;
            end
        end
        if (e_stall && m_scnt < SCNT_MAX) m_scnt++;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".stallF"}, 32'(hz_bus.stallF), 32'(e_stall));
        chk({tag, ".stallD"}, 32'(hz_bus.stallD), 32'(e_stall));
        chk({tag, ".stallE"}, 32'(hz_bus.stallE), 32'(hz_bus.stallreq_mem));
        chk({tag, ".stallM"}, 32'(hz_bus.stallM), 32'(hz_bus.stallreq_mem));
        chk({tag, ".flushF"}, 32'(hz_bus.flushF), 32'(e_ff));
        chk({tag, ".flushD"}, 32'(hz_bus.flushD), 32'(e_fd));
        chk({tag, ".flushE"}, 32'(hz_bus.flushE), 32'(e_fe));
        chk({tag, ".flushM"}, 32'(hz_bus.flushM), 32'(e_fm));
        chk({tag, ".flushW"}, 32'(hz_bus.flushW), 32'(e_fw));
        chk({tag, ".fwdA"}, 32'(hz_bus.forwardaE), 32'(e_fwa));
        chk({tag, ".fwdB"}, 32'(hz_bus.forwardbE), 32'(e_fwb));
        chk({tag, ".rvalid"}, 32'(hz_bus.redirect_valid), 32'(m_mode == M_RED));
        chk({tag, ".rpc"}, hz_bus.redirect_pc, m_rpc);
        chk({tag, ".sb_full"}, 32'(hz_bus.sb_full), 32'(m_cnt == SB_DEPTH));
        chk({tag, ".stall_cnt"}, 32'(hz_bus.stall_cnt), 32'(m_scnt));
    endtask

    task automatic settle(input string tag);
        @(negedge clk);
        model_eval();
        check_all(tag);
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        hz_bus.rsD = 5'd1; hz_bus.rtD = 5'd2; hz_bus.rsE = 5'd0; hz_bus.rtE = 5'd0;
        hz_bus.issue_valid = 0; hz_bus.issue_long = 0; hz_bus.issue_wreg = 5'd0;
        hz_bus.lwb_valid = 0; hz_bus.lwb_reg = 5'd0;
        hz_bus.writeregM = 5'd0; hz_bus.writeregW = 5'd0;
        hz_bus.regwriteM = 0; hz_bus.regwriteW = 0;
        hz_bus.memtoregE = 0; hz_bus.stallreq_mem = 0;
        hz_bus.excepttypeM = 32'h0; hz_bus.cp0_epcM = 32'h0; hz_bus.pc_ready = 1;
    endtask

    initial begin
        rst = 1'b1;
        quiet();
        model_reset();
        #1;
        check_all("reset");
        chk("reset_rpc", hz_bus.redirect_pc, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Long div to r5, dependent decode stalls until its writeback.
        hz_bus.issue_valid = 1; hz_bus.issue_long = 1; hz_bus.issue_wreg = 5'd5;
        settle("div_issue"); tick();
        hz_bus.issue_valid = 0; hz_bus.issue_long = 0; hz_bus.rsD = 5'd5;
        for (int i = 0; i < 3; i++) begin
            settle("div_wait"); chk("div_wait_stallD", 32'(hz_bus.stallD), 32'd1); tick();
        end
        hz_bus.lwb_valid = 1; hz_bus.lwb_reg = 5'd5;
        settle("div_wb"); chk("div_wb_stallD", 32'(hz_bus.stallD), 32'd0); tick();
        hz_bus.lwb_valid = 0;
        settle("div_done"); chk("div_done_stallD", 32'(hz_bus.stallD), 32'd0); tick();

        // Fill the scoreboard, then a fifth long op waits for a writeback.
        hz_bus.rsD = 5'd10; hz_bus.rtD = 5'd11;
        for (int i = 1; i <= 4; i++) begin
            hz_bus.issue_valid = 1; hz_bus.issue_long = 1; hz_bus.issue_wreg = 5'(i);
            settle("fill"); tick();
        end
        hz_bus.issue_valid = 0; hz_bus.issue_long = 0;
        settle("full"); chk("full_sb_full", 32'(hz_bus.sb_full), 32'd1); tick();
        hz_bus.issue_valid = 1; hz_bus.issue_long = 1; hz_bus.issue_wreg = 5'd6;
        for (int i = 0; i < 2; i++) begin
            settle("fifth"); chk("fifth_stallD", 32'(hz_bus.stallD), 32'd1); tick();
        end
        hz_bus.lwb_valid = 1; hz_bus.lwb_reg = 5'd2;
        settle("fifth_wb"); tick();
        hz_bus.lwb_valid = 0;
        settle("fifth_go"); chk("fifth_go_stallD", 32'(hz_bus.stallD), 32'd0); tick();
        hz_bus.issue_valid = 0; hz_bus.issue_long = 0;

        // Ordinary exception: flush cycle, then redirect to the vector.
        hz_bus.excepttypeM = 32'h4;
        settle("exc"); tick();
        hz_bus.excepttypeM = 32'h0;
        settle("exc_flush");
        chk("flushF", 32'(hz_bus.flushF), 32'd1);
        chk("flushD", 32'(hz_bus.flushD), 32'd1);
        chk("flushE", 32'(hz_bus.flushE), 32'd1);
        chk("flushM", 32'(hz_bus.flushM), 32'd1);
        chk("flushW", 32'(hz_bus.flushW), 32'd1);
        tick();
        hz_bus.pc_ready = 0;
        for (int i = 0; i < 3; i++) begin
            settle("exc_wait");
            chk("exc_wait_rvalid", 32'(hz_bus.redirect_valid), 32'd1);
            chk("exc_wait_rpc", hz_bus.redirect_pc, 32'hBFC00380);
            chk("exc_wait_stallF", 32'(hz_bus.stallF), 32'd1);
            tick();
        end
        hz_bus.pc_ready = 1;
        settle("exc_accept"); chk("exc_accept_sb_full", 32'(hz_bus.sb_full), 32'd0); tick();
        settle("exc_idle"); chk("exc_idle_rvalid", 32'(hz_bus.redirect_valid), 32'd0); tick();

        // ERET returns to EPC; an exception during redirect is dropped.
        hz_bus.excepttypeM = ERET; hz_bus.cp0_epcM = 32'h80001000;
        settle("eret"); tick();
        hz_bus.excepttypeM = 32'h0;
        settle("eret_flush"); tick();
        hz_bus.pc_ready = 0; hz_bus.excepttypeM = 32'h4; hz_bus.cp0_epcM = 32'h12345678;
        settle("eret_red"); chk("eret_rpc", hz_bus.redirect_pc, 32'h80001000); tick();
        hz_bus.excepttypeM = 32'h0;
        settle("eret_ign");
        chk("eret_ign_rvalid", 32'(hz_bus.redirect_valid), 32'd1);
        chk("eret_ign_rpc", hz_bus.redirect_pc, 32'h80001000);
        tick();
        hz_bus.pc_ready = 1;
        settle("eret_accept"); tick();
        settle("eret_idle"); chk("eret_idle_rvalid", 32'(hz_bus.redirect_valid), 32'd0); tick();

        // Forwarding priority.
        hz_bus.rsE = 5'd3; hz_bus.rtE = 5'd3; hz_bus.writeregM = 5'd3; hz_bus.writeregW = 5'd3;
        hz_bus.regwriteM = 1; hz_bus.regwriteW = 1;
        settle("fwd_m"); chk("fwd_m_a", 32'(hz_bus.forwardaE), 32'd2);
        chk("fwd_m_b", 32'(hz_bus.forwardbE), 32'd2); tick();
        hz_bus.regwriteM = 0;
        settle("fwd_w"); chk("fwd_w_a", 32'(hz_bus.forwardaE), 32'd1); tick();
        hz_bus.regwriteM = 1; hz_bus.rsE = 5'd0;
        settle("fwd_r0"); chk("fwd_r0_a", 32'(hz_bus.forwardaE), 32'd0); tick();
        quiet();

        // Stall counter saturates.
        hz_bus.stallreq_mem = 1;
        for (int i = 0; i < 20; i++) begin
            settle("mem_stall"); tick();
        end
        hz_bus.stallreq_mem = 0;
        settle("sat"); chk("sat_stall_cnt", 32'(hz_bus.stall_cnt), 32'hF); tick();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            int r;
            hz_bus.rsD = 5'($urandom_range(0, 7)); hz_bus.rtD = 5'($urandom_range(0, 7));
            hz_bus.rsE = 5'($urandom_range(0, 7)); hz_bus.rtE = 5'($urandom_range(0, 7));
            hz_bus.issue_valid = 1'($urandom_range(0, 1));
            hz_bus.issue_long  = ($urandom_range(0, 2) == 0);
            hz_bus.issue_wreg  = 5'($urandom_range(0, 7));
            hz_bus.lwb_valid   = ($urandom_range(0, 2) == 0);
            hz_bus.lwb_reg     = 5'($urandom_range(0, 7));
            hz_bus.writeregM   = 5'($urandom_range(0, 7));
            hz_bus.writeregW   = 5'($urandom_range(0, 7));
            hz_bus.regwriteM   = 1'($urandom_range(0, 1));
            hz_bus.regwriteW   = 1'($urandom_range(0, 1));
            hz_bus.memtoregE   = ($urandom_range(0, 3) == 0);
            hz_bus.stallreq_mem = ($urandom_range(0, 7) == 0);
            r = $urandom_range(0, 15);
            hz_bus.excepttypeM = (r == 0) ? 32'h4 : (r == 1) ? ERET : 32'h0;
            hz_bus.cp0_epcM    = $urandom;
            hz_bus.pc_ready    = 1'($urandom_range(0, 1));
            settle("rand"); tick();
        end

        // Reset asserted while waiting in redirect.
        quiet();
        for (int i = 0; i < 3; i++) begin
            settle("drain"); tick();
        end
        hz_bus.excepttypeM = 32'h4;
        settle("rst_exc"); tick();
        hz_bus.excepttypeM = 32'h0;
        settle("rst_flush"); tick();
        hz_bus.pc_ready = 0;
        settle("rst_red"); chk("rst_red_rvalid", 32'(hz_bus.redirect_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_rvalid", 32'(hz_bus.redirect_valid), 32'd0);
        chk("arst_rpc", hz_bus.redirect_pc, 32'h0);
        chk("arst_stallF", 32'(hz_bus.stallF), 32'd0);
        chk("arst_sb_full", 32'(hz_bus.sb_full), 32'd0);
        chk("arst_stall_cnt", 32'(hz_bus.stall_cnt), 32'd0);
        chk("arst_flushes", 32'({hz_bus.flushF, hz_bus.flushD, hz_bus.flushE,
                                 hz_bus.flushM, hz_bus.flushW}), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        settle("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
